// File: rtl/blinky_mem_arb.sv
// ----------------------------------------------------------------------------
// Module   : blinky_mem_arb
// Function : Two-port arbiter in front of an 8x32 register memory, with a
//            blink output that toggles every BLINK_DIV completed accesses.
// Config   : `define BLINKY_ARB_RR_EN selects round-robin arbitration;
//            otherwise port 0 has fixed priority.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module blinky_mem_arb #(
  parameter int BLINK_DIV = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic        we0_i,
  input  logic        we1_i,
  input  logic [2:0]  addr0_i,
  input  logic [2:0]  addr1_i,
  input  logic [31:0] wdata0_i,
  input  logic [31:0] wdata1_i,
  output logic        gnt0_o,
  output logic        gnt1_o,
  output logic        rvalid0_o,
  output logic        rvalid1_o,
  output logic [31:0] rdata0_o,
  output logic [31:0] rdata1_o,
  output logic        blink_o
);

  localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        sel_q, sel_d;       // 0: port 0 owns the access, 1: port 1
  logic        we_q, we_d;
  logic [2:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic        pick1;              // arbitration winner is port 1

  logic [31:0] mem_q [8];
  logic        rvalid0_q, rvalid1_q;
  logic [31:0] rdata0_q, rdata1_q;
  logic [CW-1:0] cnt_q;
  logic        blink_q;

  // Power-up contents of the memory word at address a.
  function automatic logic [31:0] init_word(input logic [2:0] a);
    case (a)
      3'd0:    init_word = 32'h0000_00DE;
      3'd1:    init_word = 32'h0000_00AD;
      3'd2:    init_word = 32'h0000_00BE;
      3'd3:    init_word = 32'h0000_00EF;
      3'd4:    init_word = 32'h0000_0055;
      3'd5:    init_word = 32'h0000_00AA;
      3'd6:    init_word = 32'h0000_0055;
      default: init_word = 32'h0000_00AA;
    endcase
  endfunction

`ifdef BLINKY_ARB_RR_EN
  logic rr_q, rr_d;                // 1: port 1 preferred on contention

  // Winner selection: the port not granted most recently wins a tie.
  always_comb begin
    pick1 = req1_i & (~req0_i | rr_q);
    rr_d  = rr_q;
    if (state_q == IDLE && (req0_i || req1_i)) begin
      rr_d = ~pick1;
    end
  end

  // Round-robin pointer, moved only when a grant is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_q <= 1'b0;
    else     rr_q <= rr_d;
  end
`else
  // Winner selection: port 1 only wins when port 0 is silent.
  always_comb begin
    pick1 = req1_i & ~req0_i;
  end
`endif

  // Next-state and grant logic; command latched from the winner in IDLE.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_i || req1_i) begin
          state_d = ACCESS;
          sel_d   = pick1;
          we_d    = pick1 ? we1_i    : we0_i;
          addr_d  = pick1 ? addr1_i  : addr0_i;
          wdata_d = pick1 ? wdata1_i : wdata0_i;
          gnt0_d  = ~pick1;
          gnt1_d  = pick1;
        end
      end
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched command and grant pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 3'd0;
      wdata_q <= 32'd0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
    end
  end

  // Memory access, read-data return and completion/blink counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) mem_q[i] <= init_word(3'(i));
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= 32'd0;
      rdata1_q  <= 32'd0;
      cnt_q     <= '0;
      blink_q   <= 1'b0;
    end else begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      if (state_q == ACCESS) begin
        if (we_q) begin
          mem_q[addr_q] <= wdata_q;
        end else if (sel_q) begin
          rdata1_q  <= mem_q[addr_q];
          rvalid1_q <= 1'b1;
        end else begin
          rdata0_q  <= mem_q[addr_q];
          rvalid0_q <= 1'b1;
        end
        if (cnt_q == CNT_LAST) begin
          cnt_q   <= '0;
          blink_q <= ~blink_q;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  assign gnt0_o    = gnt0_q;
  assign gnt1_o    = gnt1_q;
  assign rvalid0_o = rvalid0_q;
  assign rvalid1_o = rvalid1_q;
  assign rdata0_o  = rdata0_q;
  assign rdata1_o  = rdata1_q;
  assign blink_o   = blink_q;

endmodule

`default_nettype wire

// File: tb/tb_blinky_mem_arb.sv
// ----------------------------------------------------------------------------
// Module   : tb_blinky_mem_arb
// Function : Directed self-checking bench for blinky_mem_arb. Inputs change
//            on the falling edge, outputs are sampled on the falling edge.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_blinky_mem_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [2:0]  addr0 = 3'd0, addr1 = 3'd0;
  logic [31:0] wdata0 = 32'd0, wdata1 = 32'd0;
  logic        gnt0, gnt1, rvalid0, rvalid1, blink;
  logic [31:0] rdata0, rdata1;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] INIT [8] = '{32'hDE, 32'hAD, 32'hBE, 32'hEF,
                                       32'h55, 32'hAA, 32'h55, 32'hAA};

  blinky_mem_arb #(.BLINK_DIV(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_i    (req0),
    .req1_i    (req1),
    .we0_i     (we0),
    .we1_i     (we1),
    .addr0_i   (addr0),
    .addr1_i   (addr1),
    .wdata0_i  (wdata0),
    .wdata1_i  (wdata1),
    .gnt0_o    (gnt0),
    .gnt1_o    (gnt1),
    .rvalid0_o (rvalid0),
    .rvalid1_o (rvalid1),
    .rdata0_o  (rdata0),
    .rdata1_o  (rdata1),
    .blink_o   (blink)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Pulse reset between falling edges; leaves the bench on a falling edge.
  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({gnt0, gnt1, rvalid0, rvalid1, blink} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000", {gnt0, gnt1, rvalid0, rvalid1, blink});
    end
    checks++;
    if (rdata0 !== 32'd0) begin
      errors++; $display("FAIL reset_rdata0: got %h expected 00000000", rdata0);
    end
    checks++;
    if (rdata1 !== 32'd0) begin
      errors++; $display("FAIL reset_rdata1: got %h expected 00000000", rdata1);
    end
  endtask

  // Request held during reset is granted on the first edge with rst low.
  task automatic test_first_read();
    req0 = 1'b1; we0 = 1'b0; addr0 = 3'd3;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, rvalid0} !== 3'b100) begin
      errors++; $display("FAIL first_gnt: got %b expected 100", {gnt0, gnt1, rvalid0});
    end
    req0 = 1'b0;
    @(negedge clk);
    checks++;
    if ({gnt0, rvalid0, rvalid1} !== 3'b010) begin
      errors++; $display("FAIL first_rvalid: got %b expected 010", {gnt0, rvalid0, rvalid1});
    end
    checks++;
    if (rdata0 !== 32'h0000_00EF) begin
      errors++; $display("FAIL first_rdata: got %h expected 000000ef", rdata0);
    end
    @(negedge clk);
    checks++;
    if ({rvalid0, rdata0} !== {1'b0, 32'h0000_00EF}) begin
      errors++; $display("FAIL rdata_hold: got %b/%h expected 0/000000ef", rvalid0, rdata0);
    end
  endtask

  task automatic test_write_read();
    req1 = 1'b1; we1 = 1'b1; addr1 = 3'd5; wdata1 = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1} !== 2'b01) begin
      errors++; $display("FAIL wr_gnt: got %b expected 01", {gnt0, gnt1});
    end
    req1 = 1'b0; we1 = 1'b0;
    @(negedge clk);
    checks++;
    if ({rvalid0, rvalid1} !== 2'b00) begin
      errors++; $display("FAIL wr_no_rvalid: got %b expected 00", {rvalid0, rvalid1});
    end
    req0 = 1'b1; we0 = 1'b0; addr0 = 3'd5;
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      errors++; $display("FAIL rd_gnt: got %b expected 10", {gnt0, gnt1});
    end
    req0 = 1'b0;
    @(negedge clk);
    checks++;
    if ({rvalid0, rdata0} !== {1'b1, 32'h1234_5678}) begin
      errors++; $display("FAIL wr_rd_data: got %b/%h expected 1/12345678", rvalid0, rdata0);
    end
  endtask

  task automatic test_port1_read();
    logic [2:0]  addrs [3] = '{3'd7, 3'd6, 3'd2};
    logic [31:0] exp   [3] = '{32'hAA, 32'h55, 32'hBE};
    for (int i = 0; i < 3; i++) begin
      req1 = 1'b1; we1 = 1'b0; addr1 = addrs[i];
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1} !== 2'b01) begin
        errors++; $display("FAIL p1_gnt[%0d]: got %b expected 01", i, {gnt0, gnt1});
      end
      req1 = 1'b0;
      @(negedge clk);
      checks++;
      if ({rvalid0, rvalid1, rdata1} !== {2'b01, exp[i]}) begin
        errors++;
        $display("FAIL p1_read[%0d]: got %b%b/%h expected 01/%h", i, rvalid0, rvalid1, rdata1, exp[i]);
      end
    end
  endtask

  task automatic test_contention();
    logic [1:0]  exp_g;
    logic [31:0] exp_d;
    reset_dut();
    req0 = 1'b1; we0 = 1'b0; addr0 = 3'd0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 3'd1;
    for (int i = 0; i < 6; i++) begin
`ifdef BLINKY_ARB_RR_EN
      exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
`else
      exp_g = 2'b10;
`endif
      exp_d = exp_g[0] ? 32'hAD : 32'hDE;
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1} !== exp_g) begin
        errors++; $display("FAIL cont_gnt[%0d]: got %b expected %b", i, {gnt0, gnt1}, exp_g);
      end
      if (i == 5) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      @(negedge clk);
      checks++;
      if ({rvalid0, rvalid1} !== exp_g ||
          (exp_g[1] ? rdata0 : rdata1) !== exp_d) begin
        errors++;
        $display("FAIL cont_read[%0d]: got %b/%h/%h expected %b/%h",
                 i, {rvalid0, rvalid1}, rdata0, rdata1, exp_g, exp_d);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_b;
    reset_dut();
    req0 = 1'b1; we0 = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      addr0 = 3'((k - 1) % 8);
      exp_b = (k >= 8 && k < 16);
      @(negedge clk);
      checks++;
      if (gnt0 !== 1'b1) begin
        errors++; $display("FAIL b2b_gnt[%0d]: got %b expected 1", k, gnt0);
      end
      if (k == 16) req0 = 1'b0;
      @(negedge clk);
      checks++;
      if ({rvalid0, rdata0, blink} !== {1'b1, INIT[(k - 1) % 8], exp_b}) begin
        errors++;
        $display("FAIL b2b_read[%0d]: got %b/%h/blink=%b expected 1/%h/blink=%b",
                 k, rvalid0, rdata0, blink, INIT[(k - 1) % 8], exp_b);
      end
    end
  endtask

  task automatic test_reset_abort();
    reset_dut();
    req0 = 1'b1; we0 = 1'b1; addr0 = 3'd0; wdata0 = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b1) begin
      errors++; $display("FAIL abort_gnt: got %b expected 1", gnt0);
    end
    rst = 1'b1; req0 = 1'b0; we0 = 1'b0;
    #1;
    checks++;
    if ({gnt0, gnt1} !== 2'b00) begin
      errors++; $display("FAIL abort_async_gnt: got %b expected 00", {gnt0, gnt1});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({rvalid0, rvalid1, blink} !== 3'b000) begin
        errors++; $display("FAIL abort_quiet[%0d]: got %b expected 000", i, {rvalid0, rvalid1, blink});
      end
    end
    req0 = 1'b1; addr0 = 3'd0;
    @(negedge clk);
    req0 = 1'b0;
    @(negedge clk);
    checks++;
    if ({rvalid0, rdata0} !== {1'b1, 32'h0000_00DE}) begin
      errors++; $display("FAIL abort_mem: got %b/%h expected 1/000000de", rvalid0, rdata0);
    end
  endtask

  initial begin
    test_reset();
    test_first_read();
    test_write_read();
    test_port1_read();
    test_contention();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
